// File: rtl/fetch_unit_if.sv
`default_nettype none
//============================================================================
// fetch_unit_if : memory-side and decode-side signal bundle of fetch_unit
// Rev 1.0
//============================================================================
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        jmp_occur;
  logic [31:0] pc_jmpto;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        fetch_err;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_err,
    input  imem_gnt, imem_rvalid, imem_rdata, jmp_occur, pc_jmpto, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_err,
    output imem_gnt, imem_rvalid, imem_rdata, jmp_occur, pc_jmpto, instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
//============================================================================
// fetch_unit : RV32I fetch front end, credit-limited fetch into a FWFT buffer
// Rev 1.0
//============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rstB,
  fetch_unit_if.master bus
);

  localparam int unsigned      PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic             err_q, err_d;
  logic [31:0]      buf_instr_q [FIFO_DEPTH];
  logic [31:0]      buf_pc_q    [FIFO_DEPTH];

  logic             redirect;
  logic             target_ok;
  logic [CNT_W:0]   inflight;
  logic             credit_ok;
  logic             req;
  logic             head_valid;
  logic             fire;
  logic             resp;
  logic             resp_drop;
  logic             push;
  logic             pop;

  assign redirect  = bus.jmp_occur && (state_q != ST_IDLE);
  assign target_ok = (bus.pc_jmpto[1:0] == 2'b00);
  // Buffered plus in-flight words never exceed the buffer, so pushes always fit.
  assign inflight  = {1'b0, count_q} + {1'b0, pending_q};
  assign credit_ok = (inflight < {1'b0, CNT_MAX});
  assign fire      = req && bus.imem_gnt;
  assign resp      = bus.imem_rvalid && (pending_q != '0);
  assign resp_drop = resp && (drop_q != '0);
  assign push      = resp && !resp_drop && !redirect;
  assign pop       = head_valid && bus.instr_ready && !redirect;

  always_ff @(posedge clk) begin
    if (!rstB) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN,
      ST_ERR: begin
        if (redirect) begin
          state_d = target_ok ? ST_RUN : ST_ERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req        = 1'b0;
    head_valid = 1'b0;
    if (state_q == ST_RUN) begin
      req        = !bus.jmp_occur && credit_ok;
      head_valid = (count_q != '0);
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (fire) begin
      pending_d = pending_d + CNT_ONE;
    end
    if (resp) begin
      pending_d = pending_d - CNT_ONE;
    end

    // Everything still outstanding after a redirect belongs to the old path.
    drop_d = drop_q;
    if (redirect) begin
      drop_d = pending_d;
    end else if (resp_drop) begin
      drop_d = drop_q - CNT_ONE;
    end

    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (redirect) begin
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + PTR_ONE;
      end
      if (pop) begin
        rptr_d = rptr_q + PTR_ONE;
      end
      if (push && !pop) begin
        count_d = count_q + CNT_ONE;
      end else if (pop && !push) begin
        count_d = count_q - CNT_ONE;
      end
    end

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    if (redirect && target_ok) begin
      fetch_pc_d = bus.pc_jmpto;
      resp_pc_d  = bus.pc_jmpto;
    end else begin
      if (fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
      end
    end

    err_d = err_q;
    if (redirect) begin
      err_d = !target_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstB) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      pending_q  <= '0;
      drop_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      drop_q     <= drop_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr_q[wptr_q] <= bus.imem_rdata;
      buf_pc_q[wptr_q]    <= resp_pc_q + 32'd4;
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instr_valid = head_valid;
  assign bus.instr       = head_valid ? buf_instr_q[rptr_q] : 32'h0;
  assign bus.instr_pc    = head_valid ? buf_pc_q[rptr_q] : 32'h0;
  assign bus.fetch_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
//============================================================================
// tb_fetch_unit : directed self-checking bench with an in-order memory model
// Rev 1.0
//============================================================================
module tb_fetch_unit;

  logic clk  = 1'b0;
  logic rstB = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk  (clk),
    .rstB (rstB),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  int          errors = 0;
  int          checks = 0;
  int          lat = 1;
  bit          gnt_rand = 1'b0;
  bit          stable_en = 1'b0;
  int          cyc = 0;
  rsp_t        rq[$];
  logic [31:0] issued[$];
  logic [63:0] delivered[$];

  function automatic logic [31:0] mw(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_del(input string tag, input int idx,
                         input logic [31:0] exp_pc, input logic [31:0] exp_instr);
    if (idx < delivered.size()) begin
      chk({tag, "_pc"}, delivered[idx][31:0], exp_pc);
      chk({tag, "_instr"}, delivered[idx][63:32], exp_instr);
    end else begin
      chk({tag, "_count"}, 32'(delivered.size()), 32'(idx + 1));
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_del(input string tag, input int n, input int maxc);
    int k = 0;
    while (delivered.size() < n && k < maxc) begin
      step(1);
      k++;
    end
    chk(tag, 32'(delivered.size() >= n), 32'd1);
  endtask

  task automatic do_reset(input int lat_v, input logic ready_v);
    rstB            = 1'b0;
    bus.jmp_occur   = 1'b0;
    bus.pc_jmpto    = 32'h0;
    bus.instr_ready = ready_v;
    lat             = lat_v;
    gnt_rand        = 1'b0;
    stable_en       = 1'b0;
    step(3);
    issued.delete();
    delivered.delete();
    rstB = 1'b1;
  endtask

  // In-order memory: drives at negedge, samples the handshake just before posedge.
  initial begin
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      bus.imem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rstB && rq.size() > 0 && rq[0].due <= cyc) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mw(rq[0].addr);
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
      end
      #4;
      if (!rstB) begin
        rq.delete();
        cyc = 0;
      end else begin
        if (bus.imem_rvalid && rq.size() > 0) void'(rq.pop_front());
        if (bus.imem_req && bus.imem_gnt) rq.push_back('{bus.imem_addr, cyc + lat});
        cyc++;
      end
    end
  end

  // Records fetches and deliveries; checks request stability while gnt is withheld.
  initial begin
    bit          p_wait = 1'b0;
    logic [31:0] p_addr = 32'h0;
    forever begin
      @(negedge clk);
      #4;
      if (rstB) begin
        if (bus.instr_valid && bus.instr_ready && !bus.jmp_occur)
          delivered.push_back({bus.instr, bus.instr_pc});
        if (bus.imem_req && bus.imem_gnt)
          issued.push_back(bus.imem_addr);
        if (stable_en && p_wait && !bus.jmp_occur) begin
          chk("req_hold", 32'(bus.imem_req), 32'd1);
          chk("addr_hold", bus.imem_addr, p_addr);
        end
        p_wait = bus.imem_req && !bus.imem_gnt;
        p_addr = bus.imem_addr;
      end else begin
        p_wait = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int  n;
    bit  found;

    // Reset values and sequential fetch from RESET_PC.
    bus.jmp_occur   = 1'b0;
    bus.pc_jmpto    = 32'h0;
    bus.instr_ready = 1'b1;
    step(3);
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_err", 32'(bus.fetch_err), 32'd0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
    rstB = 1'b1;
    step(1);
    chk("first_req", 32'(bus.imem_req), 32'd1);
    chk("first_addr", bus.imem_addr, 32'h0);
    step(1);
    chk("valid_t2", 32'(bus.instr_valid), 32'd0);
    step(1);
    chk("valid_t3", 32'(bus.instr_valid), 32'd1);
    chk("head_pc_t3", bus.instr_pc, 32'h4);
    chk("head_instr_t3", bus.instr, mw(32'h0));
    step(20);
    chk_del("seq0", 0, 32'h4, mw(32'h0));
    chk_del("seq1", 1, 32'h8, mw(32'h4));
    chk_del("seq2", 2, 32'hC, mw(32'h8));
    chk_del("seq3", 3, 32'h10, mw(32'hC));

    // Decode stalled: credits stop fetch after two words.
    do_reset(1, 1'b0);
    step(12);
    chk("stall_issued", 32'(issued.size()), 32'd2);
    if (issued.size() >= 2) begin
      chk("stall_addr0", issued[0], 32'h0);
      chk("stall_addr1", issued[1], 32'h4);
    end
    chk("stall_req", 32'(bus.imem_req), 32'd0);
    chk("stall_valid", 32'(bus.instr_valid), 32'd1);
    chk("stall_head_pc", bus.instr_pc, 32'h4);
    chk("stall_head_instr", bus.instr, mw(32'h0));
    bus.instr_ready = 1'b1;
    step(10);
    chk_del("drain0", 0, 32'h4, mw(32'h0));
    chk_del("drain1", 1, 32'h8, mw(32'h4));
    chk("resume_issued", 32'(issued.size() >= 3), 32'd1);
    if (issued.size() >= 3) chk("resume_addr", issued[2], 32'h8);

    // Redirect with two requests outstanding on a 3-cycle memory.
    do_reset(3, 1'b1);
    step(3);
    chk("pre_jmp_outstanding", 32'(issued.size()), 32'd2);
    bus.jmp_occur = 1'b1;
    bus.pc_jmpto  = 32'h100;
    #1;
    chk("jmp_req_forced", 32'(bus.imem_req), 32'd0);
    step(1);
    bus.jmp_occur = 1'b0;
    chk("jmp_flush_valid", 32'(bus.instr_valid), 32'd0);
    wait_del("jmp_wait", 1, 40);
    chk_del("jmp_first", 0, 32'h104, mw(32'h100));
    if (issued.size() >= 3) chk("jmp_target_addr", issued[2], 32'h100);

    // Misaligned target halts fetch; an aligned redirect recovers.
    bus.jmp_occur = 1'b1;
    bus.pc_jmpto  = 32'h102;
    step(1);
    bus.jmp_occur = 1'b0;
    chk("mis_err", 32'(bus.fetch_err), 32'd1);
    n = issued.size();
    step(10);
    chk("mis_req", 32'(bus.imem_req), 32'd0);
    chk("mis_valid", 32'(bus.instr_valid), 32'd0);
    chk("mis_no_issue", 32'(issued.size()), 32'(n));
    chk("mis_err_sticky", 32'(bus.fetch_err), 32'd1);
    delivered.delete();
    bus.jmp_occur = 1'b1;
    bus.pc_jmpto  = 32'h200;
    step(1);
    bus.jmp_occur = 1'b0;
    chk("recover_err", 32'(bus.fetch_err), 32'd0);
    wait_del("recover_wait", 1, 40);
    chk_del("recover_first", 0, 32'h204, mw(32'h200));

    // Redirect coinciding with a pop and a returning old response.
    do_reset(1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      #1;
      if (bus.instr_valid && bus.imem_rvalid && bus.imem_gnt) found = 1'b1;
    end
    chk("coinc_found", 32'(found), 32'd1);
    delivered.delete();
    bus.jmp_occur = 1'b1;
    bus.pc_jmpto  = 32'h300;
    @(posedge clk);
    #1;
    bus.jmp_occur = 1'b0;
    chk("coinc_flush_valid", 32'(bus.instr_valid), 32'd0);
    wait_del("coinc_wait", 2, 40);
    chk_del("coinc0", 0, 32'h304, mw(32'h300));
    chk_del("coinc1", 1, 32'h308, mw(32'h304));

    // Random grant stalls across the 32-bit PC wrap.
    do_reset(1, 1'b1);
    step(2);
    gnt_rand  = 1'b1;
    stable_en = 1'b1;
    delivered.delete();
    bus.jmp_occur = 1'b1;
    bus.pc_jmpto  = 32'hFFFF_FFF8;
    step(1);
    bus.jmp_occur = 1'b0;
    wait_del("wrap_wait", 3, 300);
    chk_del("wrap0", 0, 32'hFFFF_FFFC, mw(32'hFFFF_FFF8));
    chk_del("wrap1", 1, 32'h0000_0000, mw(32'hFFFF_FFFC));
    chk_del("wrap2", 2, 32'h0000_0004, mw(32'h0000_0000));
    stable_en = 1'b0;
    gnt_rand  = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end of the RV32I core; the PC-side counterpart of the branch/jump resolver.
- Owns the architectural PC and issues sequential word fetches to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions in a small FIFO and presents them to decode together with their link PC (address + 4).
- Consumes the resolver's redirect (jmp_occur, pc_jmpto): flushes the FIFO, discards in-flight responses and restarts fetch at the target.

Parameters:
RESET_PC, 32'h0000_0000, address of the first fetch after reset
FIFO_DEPTH, 2, instruction buffer entries and maximum outstanding requests; power of two, ≥2

Ports:
clk  in  1  core clock
rstB  in  1  synchronous active-low reset
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch word address, bits[1:0]=00
imem_gnt  in  1  request accepted this cycle (req&gnt = handshake)
imem_rvalid  in  1  read data valid; responses in order, ≥1 cycle after gnt
imem_rdata  in  32  instruction word
jmp_occur  in  1  redirect strobe from branch resolver
pc_jmpto  in  32  redirect target; sampled only when jmp_occur=1
instr_valid  out  1  FIFO head valid
instr  out  32  FIFO head instruction
instr_pc  out  32  FIFO head address + 4; drives resolver pc_current
instr_ready  in  1  decode accepts head (pop on valid&ready)
fetch_err  out  1  sticky misaligned-target flag

Behaviour:
- Reset (rstB=0 at posedge): fetch_pc←RESET_PC; FIFO empty; pending←0; drop←0; state←IDLE. Outputs: imem_req=0, instr_valid=0, fetch_err=0, instr=0, instr_pc=0.
- States:
  - IDLE: exists for exactly one cycle after reset, then →RUN.
  - RUN: normal fetch.
  - ERR: halted on a misaligned target.
- Request rule (RUN only): imem_req=1 iff jmp_occur=0 and (fifo_count + pending) < FIFO_DEPTH. imem_addr = fetch_pc.
  - On req&gnt: fetch_pc ← fetch_pc+4 (wraps modulo 2^32), pending+1.
  - req holds and addr stays stable until gnt.
- Response:
  - On rvalid: pending−1.
  - If drop>0: drop−1 and data is discarded.
  - Else: push {rdata, addr+4} into the FIFO. The address is tracked by a response-address counter advanced per accepted response.
  - Credit rule guarantees no overflow. An rvalid arriving with pending=0 is a protocol error; ignore it (assertion in bench).
- Pop: instr_valid&instr_ready removes the head. FIFO is first-word-fall-through, so the head is visible the cycle after the push. Zero-cycle bypass is not required.
- Simultaneous push and pop in one cycle is legal at any fill level, including full with pop.
- Redirect (jmp_occur=1, any state other than IDLE), effective at that posedge:
  - FIFO flushed; instr_valid=0 next cycle. A pop in the same cycle is discarded.
  - drop ← pending (including any gnt or rvalid that fires this cycle), so every old-path response is discarded.
  - imem_req is forced 0 in the redirect cycle.
  - If pc_jmpto[1:0]==00: fetch_pc←pc_jmpto, response-address counter←pc_jmpto, state→RUN, fetch_err←0.
  - Else: state→ERR, fetch_err←1, no requests issued. Outstanding drops still drain.
- ERR: imem_req=0, instr_valid=0. Exits only on an aligned redirect or reset.
- Back-to-back redirects: the last one wins. drop accumulates all pending.
- Fetch of the new target may issue in the cycle after the redirect while drop>0. New-path responses follow all drops because memory is in order.
- Reset mid-transfer: counters are cleared. The memory side must also be reset by the same rstB, so no stale rvalid follows.
- Latency: redirect at cycle T → earliest imem_req for target at T+1 → with 1-cycle memory, instr_valid at T+3.

Test Plan:
- Reset, RESET_PC=0, memory with gnt=1 and 1-cycle rvalid, ready=1 → addresses 0,4,8,… issued; instr_pc sequence 4,8,12; first instr_valid 3 cycles after rstB rises.
- ready=0 held → exactly 2 requests issued (0,4), then imem_req=0. FIFO holds both. Release ready → pops in order with instr_pc 4 then 8, and fetch resumes at 8.
- Two requests outstanding with 3-cycle memory latency, jmp_occur=1 with pc_jmpto=0x100 → both old responses discarded; next instr_valid has instr_pc=0x104 and instr=mem[0x100].
- jmp_occur=1 with pc_jmpto=0x102 → fetch_err=1, imem_req stays 0 indefinitely. A later jmp_occur with 0x200 → fetch_err=0 and fetching restarts at 0x200.
- Redirect coincident with pop, gnt and rvalid in the same cycle → no old instruction reaches decode; drop count equals the outstanding count; next delivered instr_pc = target+4.
- gnt randomly withheld → imem_addr stable while req=1 without gnt; PC wraps from 0xFFFF_FFFC to 0x0000_0000, with instr_pc 0x0000_0000 then 0x0000_0004.
